// File: rtl/lm_seq.sv
// lm_seq: queues up to four memory-select commands and sequences one
// local-memory pass per command (soft reset, start, wait for finish),
// with a 12-bit watchdog, sticky error and abort/flush handling.
module lm_seq (
  input  logic       CLK,
  input  logic       RESET_X,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [5:0] CMD_DATA,
  input  logic       GO,
  input  logic       ABORT,
  input  logic       ERR_CLR,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [2:0] CMD_CNT,
  output logic       LM_SOFT_RESET,
  output logic       LM_START,
  input  logic       LM_FINISH,
  output logic [1:0] MSEL_INPUTA_SEL,
  output logic [1:0] MSEL_INPUTB_SEL,
  output logic [1:0] MSEL_OUTPUTC_SEL
);
  localparam int              DEPTH   = 4;
  localparam int              WD_W    = 12;
  localparam logic [WD_W-1:0] WD_LAST = '1;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_START, S_WAIT, S_DONE, S_FLUSH
  } state_t;

  state_t               state_q, state_d;
  cmd_t   [DEPTH-1:0]   mem_q, mem_d;
  logic   [1:0]         rd_q, rd_d, wr_q, wr_d;
  logic   [2:0]         cnt_q, cnt_d;
  logic   [WD_W-1:0]    wd_q, wd_d;
  logic                 err_q, err_d;
  cmd_t                 sel_q, sel_d;
  logic                 timeout, flush, pop, push;

  // Moore decodes of the state register; a LOAD pop frees a slot, so a
  // full queue still accepts a push in that cycle.
  assign BUSY             = (state_q != S_IDLE);
  assign DONE             = (state_q == S_DONE);
  assign LM_SOFT_RESET    = (state_q == S_CLEAR) || (state_q == S_FLUSH);
  assign LM_START         = (state_q == S_START);
  assign CMD_READY        = (cnt_q != 3'(DEPTH)) || (state_q == S_LOAD);
  assign CMD_CNT          = cnt_q;
  assign ERR              = err_q;
  assign MSEL_INPUTA_SEL  = sel_q.a;
  assign MSEL_INPUTB_SEL  = sel_q.b;
  assign MSEL_OUTPUTC_SEL = sel_q.c;

  // Sequencer next state, watchdog and sticky error; abort outranks finish
  // and timeout, and finish outranks timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    timeout = 1'b0;
    if (state_q != S_IDLE && ABORT) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE:  if (GO && cnt_q != '0 && !err_q && !ABORT) state_d = S_LOAD;
        S_LOAD:  state_d = S_CLEAR;
        S_CLEAR: state_d = S_START;
        S_START: begin
          state_d = S_WAIT;
          wd_d    = '0;
        end
        S_WAIT: begin
          wd_d = wd_q + 12'd1;
          if (LM_FINISH) begin
            state_d = (cnt_q != '0) ? S_LOAD : S_DONE;
          end else if (wd_d == WD_LAST) begin
            timeout = 1'b1;
            state_d = S_FLUSH;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_FLUSH: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    err_d = timeout || (err_q && !ERR_CLR);
  end

  // Command FIFO: push and pop may coincide; abort or flush empties it and
  // swallows any push offered in the same cycle.
  always_comb begin
    flush = ABORT || (state_q == S_FLUSH);
    pop   = (state_q == S_LOAD) && !ABORT;
    push  = CMD_VALID && CMD_READY && !flush;
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = cmd_t'(CMD_DATA);
        wr_d        = wr_q + 2'd1;
      end
      if (pop) begin
        sel_d = mem_q[rd_q];
        rd_d  = rd_q + 2'd1;
      end
      cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // All state registers; reset abandons any pass in flight.
  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state_q <= S_IDLE;
      mem_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_lm_seq.sv
// tb_lm_seq: scenario tasks against a schedule model of lm_seq plus a
// behavioural local-memory responder with per-pass finish delays.
module tb_lm_seq;
  logic       CLK = 1'b0, RESET_X = 1'b1, CMD_VALID = 1'b0, GO = 1'b0;
  logic       ABORT = 1'b0, ERR_CLR = 1'b0, LM_FINISH = 1'b0;
  logic [5:0] CMD_DATA = '0;
  logic       CMD_READY, BUSY, DONE, ERR, LM_SOFT_RESET, LM_START;
  logic [2:0] CMD_CNT;
  logic [1:0] ma, mb, mc;

  lm_seq dut (
    .CLK(CLK), .RESET_X(RESET_X), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_DATA(CMD_DATA), .GO(GO), .ABORT(ABORT), .ERR_CLR(ERR_CLR),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CMD_CNT(CMD_CNT),
    .LM_SOFT_RESET(LM_SOFT_RESET), .LM_START(LM_START), .LM_FINISH(LM_FINISH),
    .MSEL_INPUTA_SEL(ma), .MSEL_INPUTB_SEL(mb), .MSEL_OUTPUTC_SEL(mc)
  );

  always #5 CLK = ~CLK;

  int         vec = 0, errs = 0, cyc = 0;
  int         sr_q[$], st_q[$], done_q[$];
  logic [5:0] msel_q[$];
  int         plan_q[$], dly_q[$];   // finish delay per pass, 0 = never
  int         exp_sr[$], exp_st[$];
  int         exp_done;
  int         fin_timer = 0;
  bit         fin_armed = 0;

  // One clock: sample after the edge, log events, run the LM responder.
  task automatic step();
    @(posedge CLK); #1; cyc++;
    if (LM_SOFT_RESET) begin LM_FINISH = 1'b0; fin_armed = 0; sr_q.push_back(cyc); end
    if (LM_START) begin
      st_q.push_back(cyc); msel_q.push_back({ma, mb, mc});
      fin_timer = 0;
      if (dly_q.size() != 0) fin_timer = dly_q.pop_front();
      fin_armed = (fin_timer != 0);
    end else if (fin_armed) begin
      fin_timer--;
      if (fin_timer == 0) begin LM_FINISH = 1'b1; fin_armed = 0; end
    end
    if (DONE) done_q.push_back(cyc);
  endtask

  task automatic clear_log();
    sr_q.delete(); st_q.delete(); done_q.delete(); msel_q.delete();
  endtask

  task automatic drive_push(input logic [5:0] d);
    CMD_VALID = 1'b1; CMD_DATA = d; step(); CMD_VALID = 1'b0;
  endtask

  task automatic start_go(output int c0);
    c0 = cyc; GO = 1'b1; step(); GO = 1'b0;
  endtask

  // Step until BUSY drops, optionally toggling GO randomly (must be ignored).
  task automatic run_idle(input int budget, input bit noise, output bit ok);
    int n;
    n = 0; ok = 0;
    while (n < budget) begin
      GO = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      step(); n++;
      if (!BUSY) begin ok = 1; break; end
    end
    GO = 1'b0;
  endtask

  // Schedule of a drain started by GO in cycle c0: LOAD, CLEAR, START, then
  // WAIT until finish (d cycles after START), then next LOAD or DONE.
  function automatic void model_drain(input int c0);
    int l;
    l = c0 + 1;
    exp_sr.delete(); exp_st.delete();
    foreach (plan_q[i]) begin
      exp_sr.push_back(l + 1); exp_st.push_back(l + 2);
      l = l + 3 + plan_q[i];
    end
    exp_done = l;
  endfunction

  task automatic test_reset();
    RESET_X = 1'b1; #2; RESET_X = 1'b0;
    repeat (2) @(posedge CLK); #1;
    vec++; if ({CMD_READY, BUSY, DONE, ERR, LM_SOFT_RESET, LM_START} !== 6'b100000) begin
      errs++; $display("FAIL rst_flags: got %b exp 100000", {CMD_READY, BUSY, DONE, ERR, LM_SOFT_RESET, LM_START}); end
    vec++; if (CMD_CNT !== 3'd0) begin errs++; $display("FAIL rst_cnt: got %0d exp 0", CMD_CNT); end
    vec++; if ({ma, mb, mc} !== 6'd0) begin errs++; $display("FAIL rst_msel: got %b exp 000000", {ma, mb, mc}); end
    RESET_X = 1'b1; step();
    vec++; if (BUSY !== 1'b0) begin errs++; $display("FAIL rst_rel_busy: got %b exp 0", BUSY); end
  endtask

  task automatic test_basic();
    int c0; bit ok;
    clear_log();
    drive_push(6'b01_10_11);
    vec++; if (CMD_CNT !== 3'd1) begin errs++; $display("FAIL basic_cnt1: got %0d exp 1", CMD_CNT); end
    plan_q = '{1030}; dly_q = plan_q; start_go(c0); model_drain(c0);
    vec++; if (BUSY !== 1'b1) begin errs++; $display("FAIL basic_busy: got %b exp 1", BUSY); end
    run_idle(1100, 0, ok);
    vec++; if (!ok) begin errs++; $display("FAIL basic_drain: got busy exp idle"); end
    vec++; if (sr_q.size() != 1 || sr_q[0] != c0 + 2) begin
      errs++; $display("FAIL basic_sr: got n=%0d @%0d exp @%0d", sr_q.size(), sr_q[0], c0 + 2); end
    vec++; if (st_q.size() != 1 || st_q[0] != c0 + 3) begin
      errs++; $display("FAIL basic_st: got n=%0d @%0d exp @%0d", st_q.size(), st_q[0], c0 + 3); end
    vec++; if (done_q.size() != 1 || done_q[0] != exp_done) begin
      errs++; $display("FAIL basic_done: got n=%0d @%0d exp @%0d", done_q.size(), done_q[0], exp_done); end
    vec++; if ({ma, mb, mc} !== 6'b01_10_11) begin errs++; $display("FAIL basic_msel: got %b exp 011011", {ma, mb, mc}); end
    vec++; if (CMD_CNT !== 3'd0) begin errs++; $display("FAIL basic_cnt0: got %0d exp 0", CMD_CNT); end
  endtask

  task automatic test_full();
    logic [5:0] cmds[4]; int c0; bit ok;
    clear_log(); plan_q.delete();
    for (int i = 0; i < 4; i++) begin
      cmds[i] = 6'($urandom); drive_push(cmds[i]);
      plan_q.push_back(int'($urandom_range(1, 30)));
    end
    vec++; if (CMD_CNT !== 3'd4) begin errs++; $display("FAIL full_cnt: got %0d exp 4", CMD_CNT); end
    vec++; if (CMD_READY !== 1'b0) begin errs++; $display("FAIL full_ready: got %b exp 0", CMD_READY); end
    drive_push(6'($urandom));
    vec++; if (CMD_CNT !== 3'd4) begin errs++; $display("FAIL full_drop: got %0d exp 4", CMD_CNT); end
    dly_q = plan_q; start_go(c0);
    run_idle(500, 1, ok);
    vec++; if (!ok) begin errs++; $display("FAIL full_drain: got busy exp idle"); end
    vec++; if (st_q.size() != 4 || sr_q.size() != 4 || done_q.size() != 1) begin
      errs++; $display("FAIL full_counts: got st=%0d sr=%0d done=%0d exp 4 4 1", st_q.size(), sr_q.size(), done_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (msel_q[i] !== cmds[i]) begin errs++; $display("FAIL full_order%0d: got %b exp %b", i, msel_q[i], cmds[i]); end
    end
  endtask

  task automatic test_random();
    logic [5:0] cmds[$]; int k, c0; bit ok;
    for (int it = 0; it < 6; it++) begin
      clear_log(); cmds.delete(); plan_q.delete();
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
        cmds.push_back(6'($urandom)); drive_push(cmds[i]);
        vec++; if (CMD_CNT !== 3'(i + 1)) begin errs++; $display("FAIL rnd_cnt: got %0d exp %0d", CMD_CNT, i + 1); end
        plan_q.push_back(int'($urandom_range(1, 40)));
      end
      dly_q = plan_q; start_go(c0); model_drain(c0);
      run_idle(400, 1, ok);
      vec++; if (!ok) begin errs++; $display("FAIL rnd_drain: got busy exp idle"); end
      vec++; if (st_q.size() != k || sr_q.size() != k || done_q.size() != 1) begin
        errs++; $display("FAIL rnd_counts: got st=%0d sr=%0d done=%0d exp %0d %0d 1", st_q.size(), sr_q.size(), done_q.size(), k, k); end
      for (int i = 0; i < k; i++) begin
        vec++; if (st_q[i] !== exp_st[i] || sr_q[i] !== exp_sr[i] || msel_q[i] !== cmds[i]) begin
          errs++; $display("FAIL rnd_pass%0d: got sr@%0d st@%0d sel %b exp sr@%0d st@%0d sel %b",
                           i, sr_q[i], st_q[i], msel_q[i], exp_sr[i], exp_st[i], cmds[i]); end
      end
      vec++; if (done_q[0] !== exp_done) begin errs++; $display("FAIL rnd_done: got @%0d exp @%0d", done_q[0], exp_done); end
    end
  endtask

  task automatic test_timeout();
    int c0, s, n; bit ok;
    // finish arriving in the very cycle the watchdog expires must win
    clear_log(); drive_push(6'($urandom));
    plan_q = '{4095}; dly_q = plan_q; start_go(c0);
    run_idle(4200, 0, ok);
    vec++; if (!ok || ERR !== 1'b0 || done_q.size() != 1) begin
      errs++; $display("FAIL wd_edge: got err=%b done=%0d exp err=0 done=1", ERR, done_q.size()); end
    // no finish at all: error after 4095 WAIT cycles, ERR_CLR loses to set
    clear_log(); drive_push(6'($urandom)); drive_push(6'($urandom));
    plan_q = '{0}; dly_q = plan_q; start_go(c0); s = c0 + 3;
    n = 0;
    while (ERR !== 1'b1 && n < 4200) begin
      if (cyc >= s + 4090) ERR_CLR = 1'b1;
      step(); n++;
    end
    ERR_CLR = 1'b0;
    vec++; if (ERR !== 1'b1 || cyc != s + 4096) begin
      errs++; $display("FAIL wd_err: got err=%b @%0d exp err=1 @%0d", ERR, cyc, s + 4096); end
    vec++; if (LM_SOFT_RESET !== 1'b1 || sr_q.size() != 2) begin
      errs++; $display("FAIL wd_flush_sr: got sr=%b n=%0d exp sr=1 n=2", LM_SOFT_RESET, sr_q.size()); end
    step();
    vec++; if (BUSY !== 1'b0 || CMD_CNT !== 3'd0 || ERR !== 1'b1) begin
      errs++; $display("FAIL wd_after: got busy=%b cnt=%0d err=%b exp 0 0 1", BUSY, CMD_CNT, ERR); end
    vec++; if (done_q.size() != 0 || st_q.size() != 1) begin
      errs++; $display("FAIL wd_events: got done=%0d st=%0d exp 0 1", done_q.size(), st_q.size()); end
    clear_log(); drive_push(6'($urandom)); start_go(c0);
    vec++; if (BUSY !== 1'b0) begin errs++; $display("FAIL wd_go_ignored: got busy=%b exp 0", BUSY); end
    ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
    vec++; if (ERR !== 1'b0) begin errs++; $display("FAIL wd_clr: got err=%b exp 0", ERR); end
    plan_q = '{2}; dly_q = plan_q; start_go(c0);
    vec++; if (BUSY !== 1'b1) begin errs++; $display("FAIL wd_go_after_clr: got busy=%b exp 1", BUSY); end
    run_idle(100, 0, ok);
    vec++; if (!ok || done_q.size() != 1) begin errs++; $display("FAIL wd_rerun: got done=%0d exp 1", done_q.size()); end
  endtask

  task automatic test_abort();
    int c0, n;
    clear_log();
    for (int i = 0; i < 3; i++) drive_push(6'($urandom));
    plan_q = '{5}; dly_q = plan_q; start_go(c0);
    n = 0;
    while (!(LM_FINISH && st_q.size() != 0) && n < 50) begin step(); n++; end
    vec++; if (LM_FINISH !== 1'b1 || CMD_CNT !== 3'd2) begin
      errs++; $display("FAIL abort_setup: got fin=%b cnt=%0d exp 1 2", LM_FINISH, CMD_CNT); end
    ABORT = 1'b1; CMD_VALID = 1'b1; CMD_DATA = 6'($urandom); step(); ABORT = 1'b0; CMD_VALID = 1'b0;
    vec++; if (LM_SOFT_RESET !== 1'b1 || BUSY !== 1'b1 || CMD_CNT !== 3'd0) begin
      errs++; $display("FAIL abort_flush: got sr=%b busy=%b cnt=%0d exp 1 1 0", LM_SOFT_RESET, BUSY, CMD_CNT); end
    repeat (10) step();
    vec++; if (BUSY !== 1'b0 || CMD_CNT !== 3'd0 || st_q.size() != 1 || done_q.size() != 0) begin
      errs++; $display("FAIL abort_after: got busy=%b cnt=%0d st=%0d done=%0d exp 0 0 1 0", BUSY, CMD_CNT, st_q.size(), done_q.size()); end
    // abort while idle only empties the queue
    clear_log(); drive_push(6'($urandom)); drive_push(6'($urandom));
    ABORT = 1'b1; step(); ABORT = 1'b0;
    vec++; if (CMD_CNT !== 3'd0 || BUSY !== 1'b0 || sr_q.size() != 0) begin
      errs++; $display("FAIL abort_idle: got cnt=%0d busy=%b sr=%0d exp 0 0 0", CMD_CNT, BUSY, sr_q.size()); end
  endtask

  task automatic test_push_pop();
    logic [5:0] cmds[5]; int c0; bit ok;
    clear_log(); plan_q.delete();
    for (int i = 0; i < 4; i++) begin cmds[i] = 6'($urandom); drive_push(cmds[i]); end
    for (int i = 0; i < 5; i++) plan_q.push_back(int'($urandom_range(1, 20)));
    dly_q = plan_q; start_go(c0);
    cmds[4] = 6'($urandom); CMD_VALID = 1'b1; CMD_DATA = cmds[4];
    vec++; if (CMD_READY !== 1'b1 || CMD_CNT !== 3'd4) begin
      errs++; $display("FAIL pp_ready: got rdy=%b cnt=%0d exp 1 4", CMD_READY, CMD_CNT); end
    step(); CMD_VALID = 1'b0;
    vec++; if (CMD_CNT !== 3'd4) begin errs++; $display("FAIL pp_cnt: got %0d exp 4", CMD_CNT); end
    run_idle(500, 0, ok);
    vec++; if (!ok || st_q.size() != 5 || done_q.size() != 1) begin
      errs++; $display("FAIL pp_counts: got st=%0d done=%0d exp 5 1", st_q.size(), done_q.size()); end
    for (int i = 0; i < 5; i++) begin
      vec++; if (msel_q[i] !== cmds[i]) begin errs++; $display("FAIL pp_order%0d: got %b exp %b", i, msel_q[i], cmds[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int c0, n;
    clear_log(); drive_push(6'($urandom)); drive_push(6'($urandom));
    plan_q = '{0}; dly_q = plan_q; start_go(c0);
    n = 0;
    while (st_q.size() == 0 && n < 20) begin step(); n++; end
    repeat (3) step();
    vec++; if (BUSY !== 1'b1) begin errs++; $display("FAIL rmid_busy: got %b exp 1", BUSY); end
    #2 RESET_X = 1'b0; #1;
    vec++; if ({CMD_READY, BUSY, DONE, ERR, LM_SOFT_RESET, LM_START} !== 6'b100000 || CMD_CNT !== 3'd0) begin
      errs++; $display("FAIL rmid_flags: got %b cnt=%0d exp 100000 cnt=0",
                       {CMD_READY, BUSY, DONE, ERR, LM_SOFT_RESET, LM_START}, CMD_CNT); end
    vec++; if ({ma, mb, mc} !== 6'd0) begin errs++; $display("FAIL rmid_msel: got %b exp 000000", {ma, mb, mc}); end
    RESET_X = 1'b1; fin_armed = 0; dly_q.delete();
    repeat (20) step();
    vec++; if (done_q.size() != 0 || st_q.size() != 1 || CMD_CNT !== 3'd0 || BUSY !== 1'b0) begin
      errs++; $display("FAIL rmid_after: got done=%0d st=%0d cnt=%0d busy=%b exp 0 1 0 0", done_q.size(), st_q.size(), CMD_CNT, BUSY); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_random();
    test_timeout();
    test_abort();
    test_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got still running exp finished");
    $fatal(1, "timeout");
  end

endmodule
